jtkiwi_gfx_arb: RTL and testbench
=================================

Name: jtkiwi_gfx_arb

Overview:
- Shares the single graphics ROM SDRAM slot between the tile (scr) and sprite (obj) fetchers of the Kiwi video pipeline.
- Sits between the gfx engine's scr_*/obj_* request ports and the SDRAM bank port.
- Serialises requests and filters stale ok signals.
- Returns latched data to the winning requester.

Parameters:
- AW, 18, word address width (bits [19:2]).
- DW, 32, data width.
- HB_OBJ_PRIO, 1: when 1, obj wins contention while LHBL=0; otherwise pure round-robin.

Ports:
- rst  in  1  asynchronous reset, active high.
- clk  in  1  system clock; every flop on posedge clk, reset asynchronously by rst.
- LHBL  in  1  horizontal blank, active low.
- scr_addr  in  AW  tile fetch address.
- scr_cs  in  1  tile fetch request.
- scr_data  out  DW  tile data.
- scr_ok  out  1  tile data valid.
- obj_addr  in  AW  sprite fetch address.
- obj_cs  in  1  sprite fetch request.
- obj_data  out  DW  sprite data.
- obj_ok  out  1  sprite data valid.
- rom_addr  out  AW  SDRAM address.
- rom_cs  out  1  SDRAM request.
- rom_data  in  DW  SDRAM data.
- rom_ok  in  1  SDRAM data valid (level, may be stale for one cycle after an address change).
- st_dout  out  8  debug status.

Behaviour:
- Reset values: every output is 0; state=IDLE; owner=scr; last=obj.
- States:
  - IDLE:
    - Only one cs high -> grant that requester.
    - Both high -> grant obj if HB_OBJ_PRIO && !LHBL; else grant the requester that is not last.
    - On grant: owner=winner, latch addr into rom_addr, rom_cs<=1, go to SETTLE.
    - No cs high -> stay in IDLE, rom_cs=0.
  - SETTLE: exactly one cycle. rom_ok is ignored (stale). Go to WAIT.
  - WAIT:
    - Owner cs=0 or owner addr!=rom_addr -> abort: rom_cs<=0, no ok pulse, last=owner, go to IDLE.
    - Otherwise, if rom_ok=1 -> owner_data<=rom_data, owner_ok<=1, go to HOLD.
    - Abort takes precedence over rom_ok in the same cycle.
  - HOLD:
    - owner_ok stays 1 and owner_data stays stable while owner cs=1 and owner addr==rom_addr.
    - Otherwise: owner_ok<=0, rom_cs<=0, last=owner, go to IDLE.
    - rom_cs stays 1 in HOLD.
- Latency: cs sampled in IDLE at cycle 0; rom_cs=1 at cycle 1; rom_ok first qualifies in cycle 2; owner_ok=1 from cycle 3. Minimum request-to-ok is 3 cycles.
- Release to next grant: one IDLE cycle, so the next rom_cs rises 2 cycles after release.
- The non-owner ok is always 0. Its data output keeps its last latched value, which is never cleared except by reset.
- rom_addr changes only on grant.
- A request arriving while another is owned waits; it is never dropped while its cs is held.
- rst asserted mid-transaction: immediate return to reset values; no ok is delivered after deassert.
- Requester contract: hold addr and cs stable until ok; change or drop them to release.

Optional Feature:
- Macro JTKIWI_ARB_STATS_EN.
- Defined:
  - st_dout is an 8-bit saturating count (stops at 255) of cycles in which the non-owner had cs=1 while the arbiter was not in IDLE.
  - Cleared on the falling edge of LHBL (registered detect). The count for a line is readable during the following blank.
- Undefined: st_dout is tied to 0 and the counter logic is absent.

Test Plan:
- Single scr request: scr_cs=1, scr_addr=0x12345; rom_ok=1 held from reset -> rom_cs at cycle 1, stale ok ignored in SETTLE, scr_ok=1 at cycle 3 with scr_data=rom_data; obj_ok stays 0.
- Contention with LHBL=1: both cs rise together, last=obj -> scr granted first; obj granted 2 cycles after scr releases; rom_addr equals obj_addr.
- Blank priority: LHBL=0, HB_OBJ_PRIO=1, both request -> obj wins regardless of last; LHBL=1 -> round-robin alternates over 4 back-to-back requests (scr, obj, scr, obj).
- Abort: obj owner changes obj_addr while in WAIT, with rom_ok rising the same cycle -> no obj_ok, rom_cs=0 next cycle, new request re-granted from IDLE.
- Reset mid-HOLD: rst pulse with scr_ok=1 -> all outputs 0 asynchronously; after release with cs still high, a fresh 3-cycle handshake runs.
- JTKIWI_ARB_STATS_EN: obj waits 300 cycles during scr ownership -> st_dout=255; LHBL falling -> st_dout=0 next cycle. Built without the macro -> st_dout=0 throughout.

Source files
------------

// File: rtl/jtkiwi_gfx_arb.sv
// Graphics ROM slot arbiter: serialises tile (scr) and sprite (obj) fetches onto one SDRAM port.
// Optional JTKIWI_ARB_STATS_EN: st_dout counts cycles a request waited on the other owner.
module jtkiwi_gfx_arb #(
   parameter int AW          = 18,
   parameter int DW          = 32,
   parameter int HB_OBJ_PRIO = 1
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          LHBL,
   input  logic [AW-1:0] scr_addr,
   input  logic          scr_cs,
   output logic [DW-1:0] scr_data,
   output logic          scr_ok,
   input  logic [AW-1:0] obj_addr,
   input  logic          obj_cs,
   output logic [DW-1:0] obj_data,
   output logic          obj_ok,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [DW-1:0] rom_data,
   input  logic          rom_ok,
   output logic [7:0]    st_dout
);

   // state  | meaning
   // IDLE   | no owner, pick a winner among pending requests
   // SETTLE | first cycle of rom_cs, rom_ok still reflects the old address
   // WAIT   | waiting for rom_ok, aborted if the owner changes its request
   // HOLD   | data delivered, ok held until the owner releases
   typedef enum logic [1:0] {IDLE, SETTLE, WAIT, HOLD} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;   // 0 = scr, 1 = obj
   logic          last_q, last_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic          rom_cs_q, rom_cs_d;
   logic [DW-1:0] scr_data_q, scr_data_d, obj_data_q, obj_data_d;
   logic          scr_ok_q, scr_ok_d, obj_ok_q, obj_ok_d;

   logic          any_cs, win_obj, own_cs, own_match;
   logic [AW-1:0] own_addr;

   assign any_cs    = scr_cs | obj_cs;
   assign win_obj   = (scr_cs & obj_cs) ? (((HB_OBJ_PRIO != 0) && !LHBL) ? 1'b1 : ~last_q)
                                        : obj_cs;
   assign own_cs    = owner_q ? obj_cs : scr_cs;
   assign own_addr  = owner_q ? obj_addr : scr_addr;
   assign own_match = own_cs && (own_addr == rom_addr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         rom_addr_q <= '0;
         rom_cs_q   <= 1'b0;
         scr_data_q <= '0;
         obj_data_q <= '0;
         scr_ok_q   <= 1'b0;
         obj_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         rom_addr_q <= rom_addr_d;
         rom_cs_q   <= rom_cs_d;
         scr_data_q <= scr_data_d;
         obj_data_q <= obj_data_d;
         scr_ok_q   <= scr_ok_d;
         obj_ok_q   <= obj_ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (any_cs) begin
            owner_d = win_obj;
            state_d = SETTLE;
         end
         SETTLE: state_d = WAIT;
         WAIT: begin
            if (!own_match) begin
               last_d  = owner_q;
               state_d = IDLE;
            end else if (rom_ok) begin
               state_d = HOLD;
            end
         end
         HOLD: if (!own_match) begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rom_addr_d = rom_addr_q;
      rom_cs_d   = rom_cs_q;
      scr_data_d = scr_data_q;
      obj_data_d = obj_data_q;
      scr_ok_d   = scr_ok_q;
      obj_ok_d   = obj_ok_q;
      case (state_q)
         IDLE: begin
            rom_cs_d = any_cs;
            if (any_cs) rom_addr_d = win_obj ? obj_addr : scr_addr;
         end
         WAIT: begin
            if (!own_match) begin
               rom_cs_d = 1'b0;
            end else if (rom_ok) begin
               if (owner_q) begin
                  obj_data_d = rom_data;
                  obj_ok_d   = 1'b1;
               end else begin
                  scr_data_d = rom_data;
                  scr_ok_d   = 1'b1;
               end
            end
         end
         HOLD: if (!own_match) begin
            rom_cs_d = 1'b0;
            scr_ok_d = 1'b0;
            obj_ok_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign rom_addr = rom_addr_q;
   assign rom_cs   = rom_cs_q;
   assign scr_data = scr_data_q;
   assign obj_data = obj_data_q;
   assign scr_ok   = scr_ok_q;
   assign obj_ok   = obj_ok_q;

`ifdef JTKIWI_ARB_STATS_EN
   logic       lhbl_q;
   logic [7:0] stat_q, stat_d;
   logic       nonown_cs;

   assign nonown_cs = owner_q ? scr_cs : obj_cs;

   // Clear wins over counting so the fresh line starts from zero.
   always_comb begin
      stat_d = stat_q;
      if (lhbl_q && !LHBL)
         stat_d = '0;
      else if (state_q != IDLE && nonown_cs && stat_q != 8'hFF)
         stat_d = stat_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lhbl_q <= 1'b0;
         stat_q <= '0;
      end else begin
         lhbl_q <= LHBL;
         stat_q <= stat_d;
      end
   end

   assign st_dout = stat_q;
`else
   assign st_dout = '0;
`endif

endmodule

// File: tb/tb_jtkiwi_gfx_arb.sv
// Self-checking bench for jtkiwi_gfx_arb: a scoreboard of expected deliveries
// is filled when requests are driven and drained when an ok rises.
module tb_jtkiwi_gfx_arb;
   localparam int AW = 18;
   localparam int DW = 32;
`ifdef JTKIWI_ARB_STATS_EN
   localparam logic STATS = 1'b1;
`else
   localparam logic STATS = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1, LHBL = 1'b1;
   logic [AW-1:0] scr_addr = '0, obj_addr = '0;
   logic          scr_cs = 1'b0, obj_cs = 1'b0, rom_ok = 1'b1;
   logic [DW-1:0] scr_data, obj_data, rom_data;
   logic          scr_ok, obj_ok, rom_cs;
   logic [AW-1:0] rom_addr;
   logic [7:0]    st_dout;

   jtkiwi_gfx_arb #(.AW(AW), .DW(DW), .HB_OBJ_PRIO(1)) dut (
      .rst(rst), .clk(clk), .LHBL(LHBL),
      .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
      .st_dout(st_dout)
   );

   always #5 clk = ~clk;

   // SDRAM model: data is a fixed function of the presented address.
   assign rom_data = {rom_addr[13:0], rom_addr};

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return {a[13:0], a};
   endfunction

   typedef struct packed {
      logic          who;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic who, input logic [AW-1:0] a);
      exp_t e;
      e.who  = who;
      e.data = mdata(a);
      sb.push_back(e);
   endtask

   task automatic pop(input logic who, input logic [DW-1:0] data);
      exp_t e;
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_who", who, e.who);
         chk("sb_data", data, e.data);
      end
   endtask

   logic scr_ok_p = 1'b0, obj_ok_p = 1'b0;
   always @(negedge clk) begin
      if (scr_ok | obj_ok) chk("ok_excl", scr_ok & obj_ok, 0);
      if (scr_ok && !scr_ok_p) pop(1'b0, scr_data);
      if (obj_ok && !obj_ok_p) pop(1'b1, obj_data);
      scr_ok_p = scr_ok;
      obj_ok_p = obj_ok;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ok(input string tag);
      int n = 0;
      while (!(scr_ok | obj_ok) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, scr_ok | obj_ok, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk("rst_rom_cs", rom_cs, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_scr_ok", scr_ok, 0);
      chk("rst_obj_ok", obj_ok, 0);
      chk("rst_scr_data", scr_data, 0);
      chk("rst_obj_data", obj_data, 0);
      chk("rst_st_dout", st_dout, 0);
      rst = 1'b0;

      // single scr request with a stale rom_ok held high
      scr_addr = 18'h12345; scr_cs = 1'b1; push(1'b0, 18'h12345);
      tick();
      chk("t1_rom_cs", rom_cs, 1);
      chk("t1_rom_addr", rom_addr, 18'h12345);
      tick();
      chk("t1_stale_ok", scr_ok, 0);
      tick();
      chk("t1_scr_ok", scr_ok, 1);
      chk("t1_scr_data", scr_data, mdata(18'h12345));
      chk("t1_obj_ok", obj_ok, 0);
      scr_cs = 1'b0;
      tick();
      chk("t1_rel_rom_cs", rom_cs, 0);
      chk("t1_rel_scr_ok", scr_ok, 0);
      chk("t1_data_kept", scr_data, mdata(18'h12345));

      // contention with LHBL=1 after reset (last=obj): scr first, obj 2 cycles after release
      do_reset();
      scr_addr = 18'h0AAAA; obj_addr = 18'h15555;
      scr_cs = 1'b1; obj_cs = 1'b1;
      push(1'b0, 18'h0AAAA); push(1'b1, 18'h15555);
      tick(); tick(); tick();
      chk("t2_scr_ok", scr_ok, 1);
      chk("t2_obj_wait", obj_ok, 0);
      scr_cs = 1'b0;
      tick();
      chk("t2_gap_rom_cs", rom_cs, 0);
      tick();
      chk("t2_obj_rom_cs", rom_cs, 1);
      chk("t2_obj_rom_addr", rom_addr, 18'h15555);
      tick(); tick();
      chk("t2_obj_ok", obj_ok, 1);
      chk("t2_scr_ok_low", scr_ok, 0);
      obj_cs = 1'b0;
      tick();

      // blank priority: last=obj yet obj wins while LHBL=0
      LHBL = 1'b0;
      scr_addr = 18'h00200; obj_addr = 18'h00300;
      scr_cs = 1'b1; obj_cs = 1'b1;
      push(1'b1, 18'h00300);
      wait_ok("t3_blank");
      chk("t3_blank_obj", obj_ok, 1);
      push(1'b0, 18'h00200); push(1'b1, 18'h00301);
      push(1'b0, 18'h00201); push(1'b1, 18'h00302);
      obj_cs = 1'b0; obj_addr = 18'h00301; LHBL = 1'b1;
      tick();
      obj_cs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ok("t3_rr");
         chk("t3_rr_obj", obj_ok, (i % 2) == 1);
         if (i == 3) begin
            scr_cs = 1'b0; obj_cs = 1'b0;
            tick();
         end else if (obj_ok) begin
            obj_cs = 1'b0; obj_addr = obj_addr + 1'b1;
            tick();
            obj_cs = 1'b1;
         end else begin
            scr_cs = 1'b0; scr_addr = scr_addr + 1'b1;
            tick();
            scr_cs = 1'b1;
         end
      end

      // abort in WAIT: address changes as rom_ok rises
      rom_ok = 1'b0;
      obj_addr = 18'h3ABCD; obj_cs = 1'b1;
      tick();
      tick();
      obj_addr = 18'h3ABCE; rom_ok = 1'b1;
      push(1'b1, 18'h3ABCE);
      tick();
      chk("t4_no_ok", obj_ok, 0);
      chk("t4_rom_cs_low", rom_cs, 0);
      tick();
      chk("t4_regrant", rom_cs, 1);
      chk("t4_new_addr", rom_addr, 18'h3ABCE);
      wait_ok("t4");
      chk("t4_obj_data", obj_data, mdata(18'h3ABCE));
      obj_cs = 1'b0;
      tick();

      // reset while scr is in HOLD
      scr_addr = 18'h01234; scr_cs = 1'b1;
      push(1'b0, 18'h01234); push(1'b0, 18'h01234);
      wait_ok("t5");
      tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_scr_ok", scr_ok, 0);
      chk("t5_rst_rom_cs", rom_cs, 0);
      chk("t5_rst_rom_addr", rom_addr, 0);
      chk("t5_rst_scr_data", scr_data, 0);
      chk("t5_rst_obj_data", obj_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t5_rom_cs", rom_cs, 1);
      tick();
      chk("t5_settle_ok", scr_ok, 0);
      tick();
      chk("t5_scr_ok", scr_ok, 1);
      chk("t5_scr_data", scr_data, mdata(18'h01234));
      scr_cs = 1'b0;
      tick();

      // obj starved for 300 cycles while scr holds the slot
      scr_addr = 18'h00042; scr_cs = 1'b1;
      push(1'b0, 18'h00042);
      wait_ok("t6");
      obj_addr = 18'h00043; obj_cs = 1'b1;
      push(1'b1, 18'h00043);
      repeat (300) tick();
      chk("t6_st_sat", st_dout, STATS ? 8'd255 : 8'd0);
      LHBL = 1'b0;
      tick();
      chk("t6_st_clr", st_dout, 0);
      LHBL = 1'b1;
      scr_cs = 1'b0;
      tick();
      wait_ok("t6_obj");
      chk("t6_obj_ok", obj_ok, 1);
      obj_cs = 1'b0;
      tick();
      tick();

      chk("sb_left", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
